// File: rtl/mdioconf_miim_master.sv
// MIIM master: host config register plus Clause-45 MDIO frame serialiser.
// One frame per accepted request; MDC derived from host_clk by a per-half divider.
module mdioconf_miim_master #(
  parameter int          PREAMBLE_LEN = 32,
  parameter logic [9:0]  CONF_ADDR    = 10'h340
) (
  input  logic        host_clk,
  input  logic        host_reset,
  input  logic [1:0]  host_opcode,
  input  logic [9:0]  host_addr,
  input  logic [31:0] host_wr_data,
  output logic [31:0] host_rd_data,
  input  logic        host_miim_sel,
  input  logic        host_req,
  output logic        host_miim_rdy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_t,
  input  logic        mdio_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [5:0] LP_PRE_LAST = 6'(PREAMBLE_LEN - 1);

  state_t      r_state;
  state_t      w_state_nxt;

  logic [4:0]  r_clkdiv;
  logic        r_mdio_en;
  logic [31:0] r_rd_data;
  logic        r_rdy;
  logic        r_mdc;
  logic        r_mdio_o;
  logic        r_mdio_t;

  logic [1:0]  r_op;
  logic [9:0]  r_addr;
  logic [15:0] r_data;
  logic [4:0]  r_fdiv;
  logic [4:0]  r_div_cnt;
  logic        r_half;
  logic [5:0]  r_bit_cnt;
  logic [15:0] r_shift;

  logic        w_accept;
  logic        w_cfg_wr;
  logic        w_cfg_rd;
  logic        w_in_frame;
  logic        w_div_end;
  logic        w_bit_end;
  logic [31:0] w_frame;
  logic [4:0]  w_nidx;
  logic        w_nval;
  logic        w_ndrive;
  logic        w_unused;

  assign w_unused   = ^host_wr_data[31:16];

  assign w_accept   = host_miim_sel & host_req & r_rdy;
  assign w_cfg_wr   = ~host_miim_sel & ~host_opcode[1] & (host_addr == CONF_ADDR);
  assign w_cfg_rd   = ~host_miim_sel & host_opcode[1];
  assign w_in_frame = (r_state == S_PREAMBLE) || (r_state == S_SHIFT);
  assign w_div_end  = (r_div_cnt == r_fdiv);
  assign w_bit_end  = w_in_frame & w_div_end & r_half;
  // Post-preamble part of the frame, MSB first: ST, OP, PRTAD, DEVAD, TA, DATA
  assign w_frame    = {2'b00, r_op, r_addr, 2'b10, r_data};

  always_ff @(posedge host_clk or posedge host_reset) begin
    if (host_reset) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next state, plus the value/drive of the bit that starts on this edge
  always_comb begin
    w_state_nxt = r_state;
    w_nidx      = 5'd0;
    case (r_state)
      S_IDLE:     if (w_accept) w_state_nxt = S_PREAMBLE;
      S_PREAMBLE: if (w_bit_end && (r_bit_cnt == LP_PRE_LAST)) w_state_nxt = S_SHIFT;
      S_SHIFT: begin
        w_nidx = r_bit_cnt[4:0] + 5'd1;
        if (w_bit_end && (r_bit_cnt == 6'd31)) w_state_nxt = S_DONE;
      end
      S_DONE:     w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
    w_nval   = (w_state_nxt == S_SHIFT) ? w_frame[5'd31 - w_nidx] : 1'b1;
    w_ndrive = (w_state_nxt != S_SHIFT) | ~r_op[1] | (w_nidx < 5'd14);
  end

  always_ff @(posedge host_clk or posedge host_reset) begin
    if (host_reset) begin
      r_clkdiv  <= '0;
      r_mdio_en <= 1'b0;
      r_rd_data <= '0;
      r_rdy     <= 1'b0;
      r_mdc     <= 1'b0;
      r_mdio_o  <= 1'b1;
      r_mdio_t  <= 1'b1;
      r_op      <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_fdiv    <= '0;
      r_div_cnt <= '0;
      r_half    <= 1'b0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      if (w_cfg_wr) begin
        r_clkdiv  <= host_wr_data[4:0];
        r_mdio_en <= host_wr_data[5];
      end
      if (w_cfg_rd)
        r_rd_data <= (host_addr == CONF_ADDR) ? {26'b0, r_mdio_en, r_clkdiv} : 32'h0;
      r_rdy <= (w_state_nxt == S_IDLE) & r_mdio_en & (r_clkdiv != 5'd0);

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op      <= host_opcode;
            r_addr    <= host_addr;
            r_data    <= host_wr_data[15:0];
            r_fdiv    <= r_clkdiv;
            r_div_cnt <= '0;
            r_half    <= 1'b0;
            r_bit_cnt <= '0;
            r_mdc     <= 1'b0;
            r_mdio_o  <= w_nval;
            r_mdio_t  <= ~w_ndrive;
          end
        end
        S_PREAMBLE, S_SHIFT: begin
          if (!w_div_end) begin
            r_div_cnt <= r_div_cnt + 5'd1;
          end else begin
            r_div_cnt <= '0;
            if (!r_half) begin
              r_half <= 1'b1;
              r_mdc  <= 1'b1;
              if ((r_state == S_SHIFT) && r_op[1] && (r_bit_cnt >= 6'd16))
                r_shift <= {r_shift[14:0], mdio_i};
            end else begin
              r_half <= 1'b0;
              r_mdc  <= 1'b0;
              if (w_state_nxt != r_state) r_bit_cnt <= '0;
              else                        r_bit_cnt <= r_bit_cnt + 6'd1;
              if (w_state_nxt == S_DONE) begin
                r_mdio_o <= 1'b1;
                r_mdio_t <= 1'b1;
              end else begin
                r_mdio_o <= w_nval | ~w_ndrive;
                r_mdio_t <= ~w_ndrive;
              end
            end
          end
        end
        S_DONE: begin
          // Frame result takes priority over a coincident config read
          if (r_op[1]) r_rd_data <= {16'b0, r_shift};
        end
        default: ;
      endcase
    end
  end

  assign host_rd_data  = r_rd_data;
  assign host_miim_rdy = r_rdy;
  assign mdc           = r_mdc;
  assign mdio_o        = r_mdio_o;
  assign mdio_t        = r_mdio_t;

endmodule

// File: tb/tb_mdioconf_miim_master.sv
// Bench for mdioconf_miim_master: config table, directed MIIM frames and random
// frames checked against a bit-list model of the Clause-45 frame and a PHY model.
module tb_mdioconf_miim_master;
  localparam int PL = 32;

  logic        host_clk = 1'b0;
  logic        host_reset;
  logic [1:0]  host_opcode;
  logic [9:0]  host_addr;
  logic [31:0] host_wr_data;
  logic [31:0] host_rd_data;
  logic        host_miim_sel;
  logic        host_req;
  logic        host_miim_rdy;
  logic        mdc;
  logic        mdio_o;
  logic        mdio_t;
  logic        mdio_i = 1'b1;

  mdioconf_miim_master #(.PREAMBLE_LEN(PL), .CONF_ADDR(10'h340)) dut (
    .host_clk(host_clk), .host_reset(host_reset), .host_opcode(host_opcode),
    .host_addr(host_addr), .host_wr_data(host_wr_data), .host_rd_data(host_rd_data),
    .host_miim_sel(host_miim_sel), .host_req(host_req), .host_miim_rdy(host_miim_rdy),
    .mdc(mdc), .mdio_o(mdio_o), .mdio_t(mdio_t), .mdio_i(mdio_i));

  always #5 host_clk = ~host_clk;

  int cyc = 0;
  always @(posedge host_clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Bus observer: one {mdio_t, mdio_o} entry and one time stamp per MDC rise
  bit [1:0] rise_q[$];
  int       rise_cyc[$];
  always @(posedge mdc) begin
    rise_q.push_back({mdio_t, mdio_o});
    rise_cyc.push_back(int'($time / 10));
  end

  // PHY model: drives the read data bits, changing at the MDC fall that starts each bit
  logic [15:0] phy_data = 16'h0;
  always @(negedge mdc) begin
    int idx;
    idx = rise_q.size();
    if (idx >= PL + 16 && idx <= PL + 31) mdio_i = phy_data[PL + 31 - idx];
    else                                  mdio_i = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_idle_inputs();
    host_miim_sel = 1'b1;
    host_req      = 1'b0;
    host_opcode   = 2'b00;
    host_addr     = 10'h0;
    host_wr_data  = 32'h0;
  endtask

  task automatic cfg_wr(input logic [1:0] op, input logic [9:0] addr, input logic [31:0] d);
    host_miim_sel = 1'b0;
    host_req      = 1'b0;
    host_opcode   = op;
    host_addr     = addr;
    host_wr_data  = d;
    @(negedge host_clk);
    bus_idle_inputs();
  endtask

  task automatic cfg_rd(input logic [1:0] op, input logic [9:0] addr, output logic [31:0] d);
    host_miim_sel = 1'b0;
    host_req      = 1'b0;
    host_opcode   = op;
    host_addr     = addr;
    @(negedge host_clk);
    d = host_rd_data;
    bus_idle_inputs();
  endtask

  // Number of frame bits that differ from the Clause-45 frame built from op/addr/data
  function automatic int frame_errors(input logic [1:0] op, input logic [9:0] addr,
                                      input logic [15:0] data);
    bit exp_t[$];
    bit exp_o[$];
    int bad = 0;
    for (int i = 0; i < PL; i++) begin exp_t.push_back(1'b0); exp_o.push_back(1'b1); end
    for (int i = 0; i < 2; i++) begin exp_t.push_back(1'b0); exp_o.push_back(1'b0); end
    for (int i = 1; i >= 0; i--) begin exp_t.push_back(1'b0); exp_o.push_back(op[i]); end
    for (int i = 9; i >= 0; i--) begin exp_t.push_back(1'b0); exp_o.push_back(addr[i]); end
    if (!op[1]) begin
      exp_t.push_back(1'b0); exp_o.push_back(1'b1);
      exp_t.push_back(1'b0); exp_o.push_back(1'b0);
      for (int i = 15; i >= 0; i--) begin exp_t.push_back(1'b0); exp_o.push_back(data[i]); end
    end else begin
      for (int i = 0; i < 18; i++) begin exp_t.push_back(1'b1); exp_o.push_back(1'b1); end
    end
    if (rise_q.size() != exp_t.size()) return 1000 + rise_q.size();
    for (int i = 0; i < exp_t.size(); i++) begin
      if (rise_q[i][1] != exp_t[i]) bad++;
      else if (!exp_t[i] && rise_q[i][0] != exp_o[i]) bad++;
    end
    return bad;
  endfunction

  function automatic int period_errors(input int div);
    int bad = 0;
    for (int i = 1; i < rise_cyc.size(); i++)
      if (rise_cyc[i] - rise_cyc[i-1] != 2 * (div + 1)) bad++;
    return bad;
  endfunction

  task automatic wait_rdy(input string tag);
    int n = 0;
    while (!host_miim_rdy && n < 20000) begin @(negedge host_clk); n++; end
    if (n >= 20000) chk({tag, "_rdy_timeout"}, 32'd0, 32'd1);
  endtask

  // One MIIM transaction with full checking; extra_at>0 pulses a stray host_req mid-frame
  task automatic run_check(input logic [1:0] op, input logic [9:0] addr, input logic [15:0] data,
                           input int div, input logic [15:0] phy, input int extra_at,
                           input string tag);
    logic [31:0] prev;
    int acc;
    int n;
    wait_rdy({tag, "_pre"});
    prev = host_rd_data;
    phy_data = phy;
    rise_q.delete();
    rise_cyc.delete();
    host_miim_sel = 1'b1;
    host_opcode   = op;
    host_addr     = addr;
    host_wr_data  = {16'hDEAD, data};
    host_req      = 1'b1;
    @(negedge host_clk);
    host_req = 1'b0;
    acc = cyc;
    chk({tag, "_rdy_low"}, {31'b0, host_miim_rdy}, 32'd0);
    n = 0;
    while (!host_miim_rdy && n < 20000) begin
      host_req = (extra_at != 0 && n == extra_at);
      @(negedge host_clk);
      n++;
    end
    host_req = 1'b0;
    if (n >= 20000) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
    chk({tag, "_latency"}, cyc - acc, (PL + 32) * 2 * (div + 1) + 1);
    chk({tag, "_bus_idle"}, {30'b0, mdio_t, mdc}, 32'h2);
    chk({tag, "_frame"}, frame_errors(op, addr, data), 32'd0);
    chk({tag, "_period"}, period_errors(div), 32'd0);
    chk({tag, "_rd_data"}, host_rd_data, op[1] ? {16'h0, phy} : prev);
    bus_idle_inputs();
  endtask

  typedef struct {
    bit          wr;
    logic [1:0]  op;
    logic [9:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp;
    int          rdy_exp;
  } cfg_vec_t;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cfg_vec_t    tbl[8];
    logic [31:0] rd;
    int          bad;
    int          div;
    logic [1:0]  op;

    tbl[0] = '{1'b1, 2'b00, 10'h341, 32'h0000_003F, 32'h0,  -1};
    tbl[1] = '{1'b0, 2'b11, 10'h340, 32'h0,         32'h29,  1};
    tbl[2] = '{1'b0, 2'b10, 10'h000, 32'h0,         32'h0,  -1};
    tbl[3] = '{1'b1, 2'b01, 10'h340, 32'hFFFF_FFC5, 32'h0,  -1};
    tbl[4] = '{1'b0, 2'b11, 10'h340, 32'h0,         32'h05,  0};
    tbl[5] = '{1'b0, 2'b11, 10'h33F, 32'h0,         32'h0,  -1};
    tbl[6] = '{1'b1, 2'b00, 10'h340, 32'h0000_0029, 32'h0,  -1};
    tbl[7] = '{1'b0, 2'b10, 10'h340, 32'h0,         32'h29,  1};

    bus_idle_inputs();
    host_reset = 1'b1;
    repeat (3) @(negedge host_clk);
    chk("reset_outputs", {host_rd_data[3:0], host_miim_rdy, mdc, mdio_o, mdio_t}, 8'b0000_0011);
    host_reset = 1'b0;

    // Unconfigured: requests are ignored and the bus stays released
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      host_req = (i % 7 == 0);
      @(negedge host_clk);
      if (host_miim_rdy || mdc || !mdio_t) bad++;
    end
    host_req = 1'b0;
    chk("noconfig_idle", bad, 0);
    chk("noconfig_no_mdc", rise_q.size(), 0);

    cfg_wr(2'b00, 10'h340, 32'h29);
    chk("cfg_rdy_edge1", {31'b0, host_miim_rdy}, 32'd0);
    @(negedge host_clk);
    chk("cfg_rdy_edge2", {31'b0, host_miim_rdy}, 32'd1);
    cfg_rd(2'b11, 10'h340, rd);
    chk("cfg_rd_340", rd, 32'h29);

    foreach (tbl[i]) begin
      if (tbl[i].wr) cfg_wr(tbl[i].op, tbl[i].addr, tbl[i].wd);
      else begin
        cfg_rd(tbl[i].op, tbl[i].addr, rd);
        chk($sformatf("tbl%0d_rd", i), rd, tbl[i].exp);
      end
      if (tbl[i].rdy_exp >= 0)
        chk($sformatf("tbl%0d_rdy", i), {31'b0, host_miim_rdy}, tbl[i].rdy_exp);
    end
    @(negedge host_clk);

    run_check(2'b01, {5'd2, 5'd1}, 16'hA5C3, 9, 16'h0, 0, "wr_a5c3");
    run_check(2'b11, {5'd2, 5'd1}, 16'h0000, 9, 16'hBEEF, 300, "rd_beef");
    repeat (100) @(negedge host_clk);
    chk("rd_stray_req_ignored", rise_q.size(), PL + 32);

    // Reset while bit 40 of a write frame is on the wire
    cfg_wr(2'b00, 10'h340, 32'h23);
    wait_rdy("rst_pre");
    rise_q.delete();
    host_opcode = 2'b01; host_addr = 10'h3FF; host_wr_data = 32'h1234;
    host_req = 1'b1;
    @(negedge host_clk);
    host_req = 1'b0;
    bad = 0;
    while (rise_q.size() < 41 && bad < 5000) begin @(negedge host_clk); bad++; end
    chk("rst_reach_bit40", rise_q.size(), 41);
    host_reset = 1'b1;
    #1;
    chk("rst_midframe", {29'b0, mdio_t, mdc, host_miim_rdy}, 32'h4);
    @(negedge host_clk);
    host_reset = 1'b0;
    cfg_rd(2'b11, 10'h340, rd);
    chk("rst_cfg_cleared", rd, 32'h0);
    chk("rst_rdy_low", {31'b0, host_miim_rdy}, 32'd0);

    // Back-to-back frames through the ready handshake
    cfg_wr(2'b00, 10'h340, 32'h22);
    run_check(2'b00, {5'd7, 5'd30}, 16'h0F0F, 2, 16'h0, 0, "b2b_addr");
    run_check(2'b10, {5'd7, 5'd30}, 16'h0000, 2, 16'h5A3C, 0, "b2b_rdinc");

    for (int t = 0; t < 6; t++) begin
      div = $urandom_range(1, 3);
      op  = 2'($urandom_range(0, 3));
      cfg_wr(2'b00, 10'h340, {26'b0, 1'b1, 5'(div)});
      run_check(op, 10'($urandom), 16'($urandom), div, 16'($urandom), 0,
                $sformatf("rand%0d", t));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
